// File: rtl/demux_pkg.sv
// Shared types for the stream_demux3 packet demultiplexer.
// Optional build macro used by the top: DEMUX_DROP_CNT_EN.
package demux_pkg;

  // Channel select encoding as presented on in_sel.
  typedef enum logic [1:0] {
    SEL_A    = 2'd0,
    SEL_B    = 2'd1,
    SEL_C    = 2'd2,
    SEL_DROP = 2'd3
  } sel_t;

  // Packet-level routing state.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_t;

  localparam int unsigned NUM_CH = 3;

  // One-hot write enable for a routed channel; drop produces no enable.
  function automatic logic [NUM_CH-1:0] sel_onehot(input sel_t sel);
    logic [NUM_CH-1:0] oh;
    oh = '0;
    case (sel)
      SEL_A:   oh[0] = 1'b1;
      SEL_B:   oh[1] = 1'b1;
      SEL_C:   oh[2] = 1'b1;
      default: oh    = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/demux_out_slice.sv
// One-entry output register slice {data, last, valid} for one demux channel.
// wr_rdy = !valid || ready, so a beat can be written in the same cycle the
// held beat is consumed, giving one beat per cycle throughput.
module demux_out_slice #(
  parameter int unsigned DATA_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              wr_rdy,
  output logic [DATA_W-1:0] data,
  output logic              last,
  output logic              valid,
  input  logic              ready
);

  // Slice can take a new beat when empty or when the held beat leaves now.
  always_comb begin
    wr_rdy = !valid || ready;
  end

  // Load on write, otherwise retire the held beat once the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      last  <= 1'b0;
      valid <= 1'b0;
    end else if (wr_en) begin
      data  <= wr_data;
      last  <= wr_last;
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux3.sv
// 1-to-3 packet demultiplexer: each whole packet is steered to channel a, b
// or c (or discarded) according to in_sel sampled on its first beat.
// Optional build macro: DEMUX_DROP_CNT_EN adds the saturating drop_cnt output.
module stream_demux3
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = 3
`ifdef DEMUX_DROP_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_sel,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] a_data,
  output logic              a_last,
  output logic              a_valid,
  input  logic              a_ready,
  output logic [DATA_W-1:0] b_data,
  output logic              b_last,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [DATA_W-1:0] c_data,
  output logic              c_last,
  output logic              c_valid,
  input  logic              c_ready
`ifdef DEMUX_DROP_CNT_EN
  , output logic [CNT_W-1:0] drop_cnt
`endif
);

  state_t            state_q, state_d;
  sel_t              sel_q, sel_d;
  sel_t              tgt;
  logic              drop_beat;
  logic              tgt_rdy;
  logic              accept;
  logic [NUM_CH-1:0] slice_rdy;
  logic [NUM_CH-1:0] wr_en;

  // Target is the live select on a first beat, the locked select afterwards.
  always_comb begin
    tgt = sel_q;
    if (state_q == IDLE) begin
      tgt = sel_t'(in_sel);
    end
    drop_beat = (state_q == DROP) || ((state_q == IDLE) && (tgt == SEL_DROP));
    case (tgt)
      SEL_A:   tgt_rdy = slice_rdy[0];
      SEL_B:   tgt_rdy = slice_rdy[1];
      SEL_C:   tgt_rdy = slice_rdy[2];
      default: tgt_rdy = 1'b1;
    endcase
    in_ready = !rst && (drop_beat || tgt_rdy);
    accept   = in_valid && in_ready;
    wr_en    = '0;
    if (accept && !drop_beat) begin
      wr_en = sel_onehot(tgt);
    end
  end

  // Next-state and select-lock logic; only accepted beats move the FSM.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (drop_beat) begin
            if (!in_last) state_d = DROP;
          end else begin
            sel_d = tgt;
            if (!in_last) state_d = ROUTE;
          end
        end
        ROUTE: begin
          if (in_last) state_d = IDLE;
        end
        DROP: begin
          if (in_last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and locked select registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= SEL_A;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  demux_out_slice #(.DATA_W(DATA_W)) u_slice_a (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en[0]),
    .wr_data (in_data),
    .wr_last (in_last),
    .wr_rdy  (slice_rdy[0]),
    .data    (a_data),
    .last    (a_last),
    .valid   (a_valid),
    .ready   (a_ready)
  );

  demux_out_slice #(.DATA_W(DATA_W)) u_slice_b (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en[1]),
    .wr_data (in_data),
    .wr_last (in_last),
    .wr_rdy  (slice_rdy[1]),
    .data    (b_data),
    .last    (b_last),
    .valid   (b_valid),
    .ready   (b_ready)
  );

  demux_out_slice #(.DATA_W(DATA_W)) u_slice_c (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en[2]),
    .wr_data (in_data),
    .wr_last (in_last),
    .wr_rdy  (slice_rdy[2]),
    .data    (c_data),
    .last    (c_last),
    .valid   (c_valid),
    .ready   (c_ready)
  );

`ifdef DEMUX_DROP_CNT_EN
  // Count discarded beats, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (accept && drop_beat && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_demux3.sv
// Directed self-checking bench for stream_demux3.
// Honours DEMUX_DROP_CNT_EN to connect and check drop_cnt.
module tb_stream_demux3;

  localparam int unsigned DATA_W = 3;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_sel;
  logic              in_last;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a_data, b_data, c_data;
  logic              a_last, b_last, c_last;
  logic              a_valid, b_valid, c_valid;
  logic              a_ready, b_ready, c_ready;
`ifdef DEMUX_DROP_CNT_EN
  logic [CNT_W-1:0]  drop_cnt;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  stream_demux3 #(
    .DATA_W (DATA_W)
`ifdef DEMUX_DROP_CNT_EN
    , .CNT_W (CNT_W)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_last  (in_last),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_last   (a_last),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_last   (b_last),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .c_data   (c_data),
    .c_last   (c_last),
    .c_valid  (c_valid),
    .c_ready  (c_ready)
`ifdef DEMUX_DROP_CNT_EN
    , .drop_cnt (drop_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [DATA_W-1:0] d, input logic [1:0] s, input logic l);
    in_data  = d;
    in_sel   = s;
    in_last  = l;
    in_valid = 1'b1;
  endtask

  initial begin
    // 1: reset with a valid beat pending
    rst = 1'b1; in_valid = 1'b1; in_sel = 2'd0; in_data = '0; in_last = 1'b0;
    a_ready = 1'b1; b_ready = 1'b1; c_ready = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    tick();
    check("rst_in_ready_hold", 32'(in_ready), 32'd0);
    check("rst_valids", {29'd0, a_valid, b_valid, c_valid}, 32'd0);
    check("rst_data", {23'd0, a_data, b_data, c_data}, 32'd0);
    check("rst_lasts", {29'd0, a_last, b_last, c_last}, 32'd0);
`ifdef DEMUX_DROP_CNT_EN
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // 2: single-beat packet to b
    drive(3'b101, 2'd1, 1'b1);
    #1;
    check("t2_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("t2_b_valid", 32'(b_valid), 32'd1);
    check("t2_b_data", 32'(b_data), 32'd5);
    check("t2_b_last", 32'(b_last), 32'd1);
    check("t2_ac_silent", {30'd0, a_valid, c_valid}, 32'd0);
    tick();
    check("t2_b_drained", 32'(b_valid), 32'd0);

    // 3: 4-beat packet to c, select changes mid-packet are ignored
    for (int i = 0; i < 4; i++) begin
      drive(DATA_W'(i + 1), (i == 0) ? 2'd2 : 2'd0, i == 3);
      #1;
      check("t3_in_ready", 32'(in_ready), 32'd1);
      tick();
      check("t3_c_valid", 32'(c_valid), 32'd1);
      check("t3_c_data", 32'(c_data), 32'(i + 1));
      check("t3_c_last", 32'(c_last), (i == 3) ? 32'd1 : 32'd0);
      check("t3_a_silent", 32'(a_valid), 32'd0);
    end
    in_valid = 1'b0;
    tick();
    check("t3_c_drained", 32'(c_valid), 32'd0);

    // 4: backpressure on a
    a_ready = 1'b0;
    drive(3'd6, 2'd0, 1'b0);
    #1;
    check("t4_beat1_ready", 32'(in_ready), 32'd1);
    tick();
    check("t4_a_beat1", {28'd0, a_valid, a_data}, {28'd0, 1'b1, 3'd6});
    drive(3'd7, 2'd1, 1'b0);
    #1;
    check("t4_beat2_blocked", 32'(in_ready), 32'd0);
    tick();
    check("t4_a_hold", {28'd0, a_valid, a_data}, {28'd0, 1'b1, 3'd6});
    check("t4_b_silent", 32'(b_valid), 32'd0);
    a_ready = 1'b1;
    #1;
    check("t4_beat2_ready", 32'(in_ready), 32'd1);
    tick();
    check("t4_a_beat2", {27'd0, a_valid, a_last, a_data}, {27'd0, 1'b1, 1'b0, 3'd7});
    drive(3'd2, 2'd2, 1'b1);
    #1;
    check("t4_beat3_ready", 32'(in_ready), 32'd1);
    tick();
    check("t4_a_beat3", {27'd0, a_valid, a_last, a_data}, {27'd0, 1'b1, 1'b1, 3'd2});
    check("t4_c_silent", 32'(c_valid), 32'd0);
    in_valid = 1'b0;
    tick();
    check("t4_a_drained", 32'(a_valid), 32'd0);

    // Stalled b blocks only packets targeting b; back-to-back to c passes
    b_ready = 1'b0;
    drive(3'd5, 2'd1, 1'b1);
    tick();
    check("iso_b_loaded", {28'd0, b_valid, b_data}, {28'd0, 1'b1, 3'd5});
    drive(3'd6, 2'd2, 1'b1);
    #1;
    check("iso_c_ready", 32'(in_ready), 32'd1);
    tick();
    check("iso_c_beat", {28'd0, c_valid, c_data}, {28'd0, 1'b1, 3'd6});
    check("iso_b_hold", {28'd0, b_valid, b_data}, {28'd0, 1'b1, 3'd5});
    drive(3'd7, 2'd1, 1'b1);
    #1;
    check("iso_b_blocked", 32'(in_ready), 32'd0);
    b_ready = 1'b1;
    #1;
    check("iso_b_unblocked", 32'(in_ready), 32'd1);
    tick();
    check("iso_b_beat", {28'd0, b_valid, b_data}, {28'd0, 1'b1, 3'd7});
    in_valid = 1'b0;
    tick();
    check("iso_drained", {29'd0, a_valid, b_valid, c_valid}, 32'd0);

    // 5: 3-beat drop packet
    for (int i = 0; i < 3; i++) begin
      drive(DATA_W'(i + 3), (i == 0) ? 2'd3 : 2'd0, i == 2);
      #1;
      check("t5_in_ready", 32'(in_ready), 32'd1);
      tick();
      check("t5_no_valid", {29'd0, a_valid, b_valid, c_valid}, 32'd0);
    end
    in_valid = 1'b0;
`ifdef DEMUX_DROP_CNT_EN
    check("t5_drop_cnt", 32'(drop_cnt), 32'd3);
`endif
    // After the drop packet, a sel=0 beat must reach a
    drive(3'd1, 2'd0, 1'b1);
    tick();
    in_valid = 1'b0;
    check("t5_after_drop_a", {28'd0, a_valid, a_data}, {28'd0, 1'b1, 3'd1});
    tick();

    // 6: reset in the middle of a routed packet to b
    drive(3'd1, 2'd1, 1'b0);
    tick();
    check("t6_b_beat1", {28'd0, b_valid, b_data}, {28'd0, 1'b1, 3'd1});
    rst = 1'b1;
    drive(3'd2, 2'd1, 1'b0);
    #1;
    check("t6_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("t6_cleared_valid", {29'd0, a_valid, b_valid, c_valid}, 32'd0);
    check("t6_cleared_data", 32'(b_data), 32'd0);
`ifdef DEMUX_DROP_CNT_EN
    check("t6_drop_cnt_cleared", 32'(drop_cnt), 32'd0);
`endif
    rst = 1'b0;
    drive(3'd3, 2'd0, 1'b0);
    #1;
    check("t6_new_pkt_ready", 32'(in_ready), 32'd1);
    tick();
    check("t6_a_beat1", {27'd0, a_valid, a_last, a_data}, {27'd0, 1'b1, 1'b0, 3'd3});
    check("t6_b_silent", 32'(b_valid), 32'd0);
    drive(3'd4, 2'd1, 1'b1);
    tick();
    in_valid = 1'b0;
    check("t6_a_beat2", {27'd0, a_valid, a_last, a_data}, {27'd0, 1'b1, 1'b1, 3'd4});
    check("t6_b_still_silent", 32'(b_valid), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
